// File: rtl/axi_pkg.sv
// Shared definitions for the AXI command arbiter: FSM states, AXI field codes and
// the 4KB boundary check used when a request is granted.
package axi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_ACK  = 2'd2
  } state_e;

  localparam logic       ATYPE_WR    = 1'b1;
  localparam logic       ATYPE_RD    = 1'b0;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] LOCK_NORMAL = 2'b00;
  localparam int unsigned BOUNDARY_4K = 4096;

  // A burst may not cross a 4KB page: offset within page plus burst bytes must fit.
  function automatic logic crosses4k(input logic [11:0] offs, input logic [7:0] len,
                                     input int unsigned asz);
    logic [23:0] span;
    span = (24'(len) + 24'd1) << asz;
    return (24'(offs) + span) > 24'(BOUNDARY_4K);
  endfunction

endpackage

// File: rtl/axi_cmd_arbiter_if.sv
// Requester, AXI address channel, B-channel observation and status signals of the arbiter.
// master = arbiter view, slave = environment (requesters + DDR slave) view.
interface axi_cmd_arbiter_if #(parameter int unsigned CNT_W = 3);

  logic             wr_req;
  logic [31:0]      wr_addr;
  logic [7:0]       wr_len;
  logic             wr_ack;
  logic             rd_req;
  logic [31:0]      rd_addr;
  logic [7:0]       rd_len;
  logic             rd_ack;
  logic             req_err;
  logic [7:0]       aid;
  logic [31:0]      aaddr;
  logic [7:0]       alen;
  logic [2:0]       asize;
  logic [1:0]       aburst;
  logic [1:0]       alock;
  logic             avalid;
  logic             aready;
  logic             atype;
  logic             bvalid;
  logic             bready;
  logic [CNT_W-1:0] outst_cnt;
  logic             cnt_err;

  modport master (
    input  wr_req, wr_addr, wr_len, rd_req, rd_addr, rd_len, aready, bvalid, bready,
    output wr_ack, rd_ack, req_err, aid, aaddr, alen, asize, aburst, alock, avalid, atype,
           outst_cnt, cnt_err
  );

  modport slave (
    output wr_req, wr_addr, wr_len, rd_req, rd_addr, rd_len, aready, bvalid, bready,
    input  wr_ack, rd_ack, req_err, aid, aaddr, alen, asize, aburst, alock, avalid, atype,
           outst_cnt, cnt_err
  );

endinterface

// File: rtl/axi_outst_counter.sv
// Counts write bursts whose B response is still pending; flags a B handshake that
// arrives when nothing is outstanding (sticky until reset).
module axi_outst_counter #(
  parameter int unsigned CNT_W = 3
) (
  input  logic             axi_clk,
  input  logic             rstn,
  input  logic             i_inc,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_err
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  // Simultaneous inc and dec cancel; an underflow is dropped and only raises the flag.
  always_ff @(posedge axi_clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else if (i_inc && !i_dec) begin
      if (r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
    end else if (i_dec && !i_inc) begin
      if (r_cnt == '0) r_err <= 1'b1;
      else             r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_cnt = r_cnt;
  assign o_err = r_err;

endmodule

// File: rtl/axi_cmd_arbiter.sv
// Round-robin arbiter sharing one AXI address channel between a write-burst requester
// and a read-back requester, with outstanding-write limiting and read-after-write blocking.
module axi_cmd_arbiter
  import axi_pkg::*;
#(
  parameter int unsigned ASIZE     = 5,
  parameter int unsigned MAX_OUTST = 4,
  parameter bit          RAW_BLOCK = 1'b1,
  parameter int unsigned CNT_W     = 3
) (
  input logic               axi_clk,
  input logic               rstn,
  axi_cmd_arbiter_if.master bus
);

  state_e           r_state;
  logic             r_lastWr;
  logic             r_avalid;
  logic             r_atype;
  logic [31:0]      r_aaddr;
  logic [7:0]       r_alen;
  logic [2:0]       r_asize;
  logic [1:0]       r_aburst;
  logic [1:0]       r_alock;
  logic [7:0]       r_aid;
  logic             r_wrAck;
  logic             r_rdAck;
  logic             r_reqErr;

  logic [CNT_W-1:0] w_outstCnt;
  logic             w_cntErr;
  logic             w_eligW;
  logic             w_eligR;
  logic             w_grant;
  logic             w_grantWr;
  logic [31:0]      w_selAddr;
  logic [7:0]       w_selLen;
  logic             w_cross;
  logic             w_incr;
  logic             w_decr;

  assign w_eligW   = bus.wr_req && (32'(w_outstCnt) < MAX_OUTST);
  assign w_eligR   = bus.rd_req && !(RAW_BLOCK && (w_outstCnt != '0));
  assign w_grant   = w_eligW || w_eligR;
  // On a tie the side that did not win last time gets the slot.
  assign w_grantWr = w_eligW && (!w_eligR || !r_lastWr);
  assign w_selAddr = w_grantWr ? bus.wr_addr : bus.rd_addr;
  assign w_selLen  = w_grantWr ? bus.wr_len  : bus.rd_len;
  assign w_cross   = crosses4k(w_selAddr[11:0], w_selLen, ASIZE);

  assign w_incr = r_avalid && bus.aready && (r_atype == ATYPE_WR);
  assign w_decr = bus.bvalid && bus.bready;

  axi_outst_counter #(
    .CNT_W (CNT_W)
  ) u_outstCounter (
    .axi_clk (axi_clk),
    .rstn    (rstn),
    .i_inc   (w_incr),
    .i_dec   (w_decr),
    .o_cnt   (w_outstCnt),
    .o_err   (w_cntErr)
  );

  // IDLE grants, ADDR holds the address stable until aready, ACK pulses the result.
  always_ff @(posedge axi_clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= ST_IDLE;
      r_lastWr <= 1'b0;
      r_avalid <= 1'b0;
      r_atype  <= 1'b0;
      r_aaddr  <= '0;
      r_alen   <= '0;
      r_asize  <= '0;
      r_aburst <= '0;
      r_alock  <= '0;
      r_aid    <= '0;
      r_wrAck  <= 1'b0;
      r_rdAck  <= 1'b0;
      r_reqErr <= 1'b0;
    end else begin
      r_wrAck  <= 1'b0;
      r_rdAck  <= 1'b0;
      r_reqErr <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_aaddr <= w_selAddr;
            r_alen  <= w_selLen;
            r_atype <= w_grantWr ? ATYPE_WR : ATYPE_RD;
            if (w_cross) begin
              r_reqErr <= 1'b1;
              r_state  <= ST_ACK;
            end else begin
              r_avalid <= 1'b1;
              r_asize  <= 3'(ASIZE);
              r_aburst <= BURST_INCR;
              r_alock  <= LOCK_NORMAL;
              r_aid    <= '0;
              r_lastWr <= w_grantWr;
              r_state  <= ST_ADDR;
            end
          end
        end
        ST_ADDR: begin
          if (bus.aready) begin
            r_avalid <= 1'b0;
            r_wrAck  <= (r_atype == ATYPE_WR);
            r_rdAck  <= (r_atype == ATYPE_RD);
            r_state  <= ST_ACK;
          end
        end
        ST_ACK:  r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.wr_ack    = r_wrAck;
  assign bus.rd_ack    = r_rdAck;
  assign bus.req_err   = r_reqErr;
  assign bus.aid       = r_aid;
  assign bus.aaddr     = r_aaddr;
  assign bus.alen      = r_alen;
  assign bus.asize     = r_asize;
  assign bus.aburst    = r_aburst;
  assign bus.alock     = r_alock;
  assign bus.avalid    = r_avalid;
  assign bus.atype     = r_atype;
  assign bus.outst_cnt = w_outstCnt;
  assign bus.cnt_err   = w_cntErr;

endmodule

// File: tb/tb_axi_cmd_arbiter.sv
// Randomized self-checking bench for axi_cmd_arbiter: one instance with read-after-write
// blocking, one without, both checked against a transaction-level model.
module tb_axi_cmd_arbiter;

  localparam int CNT_W = 3;
  localparam int MAXO  = 4;
  localparam int ASZ   = 5;

  logic axi_clk = 1'b0;
  logic rstn    = 1'b0;

  int nChecks = 0;
  int nFail   = 0;

  // Model state: outstanding writes per instance, sticky underflow, last tie winner.
  int mOut1    = 0;
  bit mErr1    = 1'b0;
  int mOut0    = 0;
  bit mLastWr0 = 1'b0;

  axi_cmd_arbiter_if #(.CNT_W(CNT_W)) bus1 ();
  axi_cmd_arbiter_if #(.CNT_W(CNT_W)) bus0 ();

  axi_cmd_arbiter #(.ASIZE(ASZ), .MAX_OUTST(MAXO), .RAW_BLOCK(1'b1), .CNT_W(CNT_W)) dut1 (
    .axi_clk (axi_clk),
    .rstn    (rstn),
    .bus     (bus1)
  );

  axi_cmd_arbiter #(.ASIZE(ASZ), .MAX_OUTST(MAXO), .RAW_BLOCK(1'b0), .CNT_W(CNT_W)) dut0 (
    .axi_clk (axi_clk),
    .rstn    (rstn),
    .bus     (bus0)
  );

  always #5 axi_clk = ~axi_clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic cycle();
    @(posedge axi_clk);
    #1;
  endtask

  function automatic bit mCross(input logic [31:0] a, input logic [7:0] l);
    int bytes;
    bytes = (int'(l) + 1) * 32;
    return (int'(a % 32'd4096) + bytes) > 4096;
  endfunction

  function automatic logic [31:0] randAddr(input logic [7:0] l);
    int span;
    logic [31:0] hi;
    span = (int'(l) + 1) * 32;
    hi = $urandom();
    return (hi & 32'hFFFF_F000) | 32'($urandom_range(0, 4096 - span));
  endfunction

  task automatic clearInputs();
    bus1.wr_req = 0; bus1.wr_addr = 0; bus1.wr_len = 0; bus1.rd_req = 0; bus1.rd_addr = 0;
    bus1.rd_len = 0; bus1.aready = 0; bus1.bvalid = 0; bus1.bready = 0;
    bus0.wr_req = 0; bus0.wr_addr = 0; bus0.wr_len = 0; bus0.rd_req = 0; bus0.rd_addr = 0;
    bus0.rd_len = 0; bus0.aready = 0; bus0.bvalid = 0; bus0.bready = 0;
  endtask

  // Address is already visible; it must stay put for dly extra cycles, then handshake.
  task automatic finishAddr1(input bit isWr, input logic [31:0] addr, input logic [7:0] len,
                             input int dly);
    logic [56:0] expF, gotF;
    logic [CNT_W+3:0] expA, gotA;
    expF = {1'b1, isWr, addr, len, 3'(ASZ), 2'b01, 2'b00, 8'h00};
    for (int i = 0; i <= dly; i++) begin
      if (i > 0) cycle();
      gotF = {bus1.avalid, bus1.atype, bus1.aaddr, bus1.alen, bus1.asize, bus1.aburst,
              bus1.alock, bus1.aid};
      nChecks++;
      if (gotF !== expF) begin
        nFail++;
        $display("[TB] FAIL addr_hold[%0d]: got %h expected %h", i, gotF, expF);
      end
    end
    bus1.aready = 1'b1;
    cycle();
    if (isWr) mOut1++;
    expA = {1'b0, isWr, !isWr, 1'b0, CNT_W'(mOut1)};
    gotA = {bus1.avalid, bus1.wr_ack, bus1.rd_ack, bus1.req_err, bus1.outst_cnt};
    nChecks++;
    if (gotA !== expA) begin
      nFail++;
      $display("[TB] FAIL ack_pulse: got %b expected %b", gotA, expA);
    end
    bus1.wr_req = 0; bus1.rd_req = 0; bus1.aready = 0;
    cycle();
    gotA = {bus1.avalid, bus1.wr_ack, bus1.rd_ack, bus1.req_err, bus1.outst_cnt};
    expA = {4'b0000, CNT_W'(mOut1)};
    nChecks++;
    if (gotA !== expA) begin
      nFail++;
      $display("[TB] FAIL ack_single_cycle: got %b expected %b", gotA, expA);
    end
  endtask

  task automatic runReq1(input bit isWr, input logic [31:0] addr, input logic [7:0] len,
                         input int dly);
    logic [3:0] got;
    if (isWr) begin bus1.wr_req = 1; bus1.wr_addr = addr; bus1.wr_len = len; end
    else      begin bus1.rd_req = 1; bus1.rd_addr = addr; bus1.rd_len = len; end
    cycle();
    if (mCross(addr, len)) begin
      got = {bus1.avalid, bus1.req_err, bus1.wr_ack, bus1.rd_ack};
      nChecks++;
      if (got !== 4'b0100 || bus1.outst_cnt !== CNT_W'(mOut1)) begin
        nFail++;
        $display("[TB] FAIL boundary_err: got %b cnt %0d expected 0100 cnt %0d",
                 got, bus1.outst_cnt, mOut1);
      end
      bus1.wr_req = 0; bus1.rd_req = 0;
      cycle();
      got = {bus1.avalid, bus1.req_err, bus1.wr_ack, bus1.rd_ack};
      nChecks++;
      if (got !== 4'b0000) begin
        nFail++;
        $display("[TB] FAIL boundary_after: got %b expected 0000", got);
      end
    end else begin
      finishAddr1(isWr, addr, len, dly);
    end
  endtask

  // bvalid alone must not count; the full bvalid&bready handshake does.
  task automatic bPulse1();
    bus1.bvalid = 1; bus1.bready = 0;
    cycle();
    nChecks++;
    if (bus1.outst_cnt !== CNT_W'(mOut1)) begin
      nFail++;
      $display("[TB] FAIL b_no_ready: got %0d expected %0d", bus1.outst_cnt, mOut1);
    end
    bus1.bready = 1;
    cycle();
    bus1.bvalid = 0; bus1.bready = 0;
    if (mOut1 > 0) mOut1--; else mErr1 = 1'b1;
    nChecks++;
    if ({bus1.cnt_err, bus1.outst_cnt} !== {mErr1, CNT_W'(mOut1)}) begin
      nFail++;
      $display("[TB] FAIL b_handshake: got err %b cnt %0d expected err %b cnt %0d",
               bus1.cnt_err, bus1.outst_cnt, mErr1, mOut1);
    end
  endtask

  task automatic test_reset();
    logic [69:0] got1, got0;
    rstn = 0;
    clearInputs();
    cycle(); cycle();
    for (int k = 0; k < 2; k++) begin
      got1 = {bus1.avalid, bus1.wr_ack, bus1.rd_ack, bus1.req_err, 3'(bus1.outst_cnt),
              bus1.cnt_err, bus1.aaddr, bus1.alen, bus1.atype, bus1.asize, bus1.aburst,
              bus1.alock, bus1.aid};
      got0 = {bus0.avalid, bus0.wr_ack, bus0.rd_ack, bus0.req_err, 3'(bus0.outst_cnt),
              bus0.cnt_err, bus0.aaddr, bus0.alen, bus0.atype, bus0.asize, bus0.aburst,
              bus0.alock, bus0.aid};
      nChecks++;
      if (got1 !== '0 || got0 !== '0) begin
        nFail++;
        $display("[TB] FAIL reset_outputs[%0d]: got %h / %h expected 0", k, got1, got0);
      end
      rstn = 1;
      cycle();
    end
  endtask

  task automatic test_single_write();
    // aready arrives after 2 cycles, so the address is held for 3 cycles.
    runReq1(1'b1, 32'h0000_0000, 8'd23, 2);
    bPulse1();
  endtask

  task automatic test_raw_block();
    logic [31:0] ra;
    logic [7:0]  rl;
    rl = 8'($urandom_range(0, 15));
    runReq1(1'b1, randAddr(rl), rl, $urandom_range(0, 2));
    rl = 8'($urandom_range(0, 15));
    ra = randAddr(rl);
    bus1.rd_req = 1; bus1.rd_addr = ra; bus1.rd_len = rl;
    for (int i = 0; i < 4; i++) begin
      cycle();
      nChecks++;
      if (bus1.avalid !== 1'b0) begin
        nFail++;
        $display("[TB] FAIL raw_blocked[%0d]: got avalid %b expected 0", i, bus1.avalid);
      end
    end
    bPulse1();
    nChecks++;
    if (bus1.avalid !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL raw_release_latency: got avalid %b expected 0", bus1.avalid);
    end
    cycle();
    finishAddr1(1'b0, ra, rl, $urandom_range(0, 2));
  endtask

  task automatic test_max_outst();
    logic [31:0] wa;
    logic [7:0]  wl;
    for (int i = 0; i < MAXO; i++) begin
      wl = 8'($urandom_range(0, 15));
      runReq1(1'b1, randAddr(wl), wl, $urandom_range(0, 3));
    end
    wl = 8'($urandom_range(0, 15));
    wa = randAddr(wl);
    bus1.wr_req = 1; bus1.wr_addr = wa; bus1.wr_len = wl;
    for (int i = 0; i < 4; i++) begin
      cycle();
      nChecks++;
      if (bus1.avalid !== 1'b0 || bus1.outst_cnt !== CNT_W'(mOut1)) begin
        nFail++;
        $display("[TB] FAIL max_outst_stall[%0d]: got avalid %b cnt %0d expected 0 cnt %0d",
                 i, bus1.avalid, bus1.outst_cnt, mOut1);
      end
    end
    bPulse1();
    cycle();
    finishAddr1(1'b1, wa, wl, $urandom_range(0, 2));
    while (mOut1 > 0) bPulse1();
  endtask

  task automatic test_4k_boundary();
    logic [7:0]  l;
    logic [31:0] a;
    runReq1(1'b1, 32'h0000_0F40, 8'd23, 0);
    for (int i = 0; i < 8; i++) begin
      l = 8'($urandom_range(1, 31));
      a = $urandom() & 32'hFFFF_F000;
      case (i % 3)
        0: a = a | 32'(4096 - (int'(l) + 1) * 32);
        1: a = a | 32'(4096 - (int'(l) + 1) * 32 + 32);
        default: begin l = 8'($urandom_range(0, 255)); a = $urandom(); end
      endcase
      runReq1(1'b0, a, l, $urandom_range(0, 2));
    end
  endtask

  task automatic test_cnt_err();
    bPulse1();
    for (int i = 0; i < 3; i++) begin
      cycle();
      nChecks++;
      if (bus1.cnt_err !== 1'b1 || bus1.outst_cnt !== '0) begin
        nFail++;
        $display("[TB] FAIL cnt_err_sticky[%0d]: got err %b cnt %0d expected err 1 cnt 0",
                 i, bus1.cnt_err, bus1.outst_cnt);
      end
    end
  endtask

  task automatic tieRound0(input bit w, input bit r);
    logic [7:0]  wl, rl;
    logic [31:0] wa, ra;
    bit eW, eR, expWr;
    logic [CNT_W+2:0] got, expv;
    wl = 8'($urandom_range(0, 15)); wa = randAddr(wl);
    rl = 8'($urandom_range(0, 15)); ra = randAddr(rl);
    bus0.wr_req = w; bus0.wr_addr = wa; bus0.wr_len = wl;
    bus0.rd_req = r; bus0.rd_addr = ra; bus0.rd_len = rl;
    eW = w && (mOut0 < MAXO);
    eR = r;
    cycle();
    if (eW || eR) begin
      expWr = eW && (!eR || !mLastWr0);
      nChecks++;
      if ({bus0.avalid, bus0.atype, bus0.aaddr} !== {1'b1, expWr, expWr ? wa : ra}) begin
        nFail++;
        $display("[TB] FAIL tie_grant: got v%b t%b %h expected v1 t%b %h", bus0.avalid,
                 bus0.atype, bus0.aaddr, expWr, expWr ? wa : ra);
      end
      bus0.aready = 1;
      cycle();
      if (expWr) mOut0++;
      mLastWr0 = expWr;
      expv = {1'b0, expWr, !expWr, CNT_W'(mOut0)};
      got  = {bus0.avalid, bus0.wr_ack, bus0.rd_ack, bus0.outst_cnt};
      nChecks++;
      if (got !== expv) begin
        nFail++;
        $display("[TB] FAIL tie_ack: got %b expected %b", got, expv);
      end
      bus0.wr_req = 0; bus0.rd_req = 0; bus0.aready = 0;
      cycle();
    end else begin
      nChecks++;
      if (bus0.avalid !== 1'b0) begin
        nFail++;
        $display("[TB] FAIL tie_idle: got avalid %b expected 0", bus0.avalid);
      end
      bus0.wr_req = 0; bus0.rd_req = 0;
    end
  endtask

  task automatic test_tie_alternation();
    for (int i = 0; i < 4; i++) tieRound0(1'b1, 1'b1);
    for (int i = 0; i < 16; i++) begin
      if (mOut0 > 0 && $urandom_range(0, 2) == 0) begin
        bus0.bvalid = 1; bus0.bready = 1;
        cycle();
        bus0.bvalid = 0; bus0.bready = 0;
        mOut0--;
        nChecks++;
        if (bus0.outst_cnt !== CNT_W'(mOut0)) begin
          nFail++;
          $display("[TB] FAIL tie_b_drain: got %0d expected %0d", bus0.outst_cnt, mOut0);
        end
      end
      tieRound0(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_mid_addr();
    logic [7:0] l;
    l = 8'($urandom_range(0, 15));
    runReq1(1'b1, randAddr(l), l, 0);
    bus1.wr_req = 1; bus1.wr_addr = randAddr(l); bus1.wr_len = l;
    cycle();
    nChecks++;
    if (bus1.avalid !== 1'b1) begin
      nFail++;
      $display("[TB] FAIL pre_reset_avalid: got %b expected 1", bus1.avalid);
    end
    rstn = 0;
    #1;
    nChecks++;
    if ({bus1.avalid, bus1.outst_cnt, bus1.cnt_err} !== '0) begin
      nFail++;
      $display("[TB] FAIL async_reset: got v%b cnt %0d err %b expected all 0",
               bus1.avalid, bus1.outst_cnt, bus1.cnt_err);
    end
    mOut1 = 0; mErr1 = 0; mOut0 = 0; mLastWr0 = 0;
    cycle();
    clearInputs();
    rstn = 1;
    cycle(); cycle();
    nChecks++;
    if ({bus1.avalid, bus1.wr_ack, bus1.outst_cnt, bus1.cnt_err} !== '0) begin
      nFail++;
      $display("[TB] FAIL post_reset_idle: got v%b ack%b cnt %0d err %b expected all 0",
               bus1.avalid, bus1.wr_ack, bus1.outst_cnt, bus1.cnt_err);
    end
    runReq1(1'b0, randAddr(l), l, 1);
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_raw_block();
    test_max_outst();
    test_4k_boundary();
    test_tie_alternation();
    test_cnt_err();
    test_reset_mid_addr();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
